// File: rtl/prm_chk_pkg.sv
// Shared definitions for the sticky edge-mask accumulator: scan FSM states and
// helpers that derive word count, index width and set-bit count width.
package prm_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    function automatic int calc_nwords(input int mask_w, input int word_w);
        return mask_w / word_w;
    endfunction

    function automatic int calc_aw(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

    function automatic int calc_cw(input int mask_w);
        return $clog2(mask_w) + 1;
    endfunction

endpackage

// File: rtl/prm_chk_popcnt.sv
// Combinational population count of one readout word.
module prm_chk_popcnt #(
    parameter  int WORD_W = 32,
    localparam int CNT_W  = $clog2(WORD_W) + 1
) (
    input  logic [WORD_W-1:0] word,
    output logic [CNT_W-1:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WORD_W; i++) begin
            cnt = cnt + CNT_W'(word[i]);
        end
    end

endmodule

// File: rtl/prm_chk_acc.sv
// Sticky OR-accumulator of a wide edge mask with registered random-access
// readout and a valid/ready scan engine (zero skipping, clear-on-read, popcount).
module prm_chk_acc
    import prm_chk_pkg::*;
#(
    parameter  int MASK_W = 4096,
    parameter  int WORD_W = 32,
    parameter  int TAG_W  = 12,
    localparam int NWORDS = calc_nwords(MASK_W, WORD_W),
    localparam int AW     = calc_aw(NWORDS),
    localparam int CW     = calc_cw(MASK_W)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clr,
    input  logic              acc_en,
    input  logic [MASK_W-1:0] edge_mask,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              scan_start,
    input  logic              scan_skip0,
    input  logic              scan_cor,
    input  logic [TAG_W-1:0]  tag_in,
    output logic [TAG_W-1:0]  tag_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [AW-1:0]     out_idx,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     popcnt
);

    localparam int            PW   = $clog2(WORD_W) + 1;
    localparam logic [AW-1:0] LAST = AW'(NWORDS - 1);

    logic [NWORDS-1:0][WORD_W-1:0] acc;
    logic [NWORDS-1:0][WORD_W-1:0] acc_next;
    scan_state_e       state;
    scan_state_e       state_next;
    logic [AW-1:0]     idx;
    logic              tail;
    logic              skip0_q;
    logic              cor_q;
    logic [WORD_W-1:0] exam_word;
    logic [PW-1:0]     exam_cnt;
    logic              exam;
    logic              skip;
    logic              capture;
    logic              last;

    assign exam_word = acc[idx];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    prm_chk_popcnt #(.WORD_W(WORD_W)) u_popcnt (
        .word (exam_word),
        .cnt  (exam_cnt)
    );

    // tail marks that the last word has been examined and only draining remains
    always_comb begin
        exam       = (state == SCAN) && !tail && (!out_valid || out_ready);
        skip       = exam && skip0_q && (exam_word == '0);
        capture    = exam && !skip;
        last       = (idx == LAST);
        state_next = state;
        case (state)
            IDLE:    if (scan_start) state_next = SCAN;
            SCAN:    if ((skip && last) || (tail && (!out_valid || out_ready))) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // New edges are ORed last so they survive both clr and clear-on-read
    always_comb begin
        acc_next = clr ? '0 : acc;
        if (capture && cor_q) acc_next[idx] = '0;
        if (acc_en) acc_next = acc_next | edge_mask;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc     <= '0;
            rd_data <= '0;
        end else begin
            acc     <= acc_next;
            rd_data <= acc[rd_addr];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx       <= '0;
            tail      <= 1'b0;
            skip0_q   <= 1'b0;
            cor_q     <= 1'b0;
            tag_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            popcnt    <= '0;
        end else begin
            if (state == IDLE && scan_start) begin
                idx     <= '0;
                tail    <= 1'b0;
                skip0_q <= scan_skip0;
                cor_q   <= scan_cor;
                tag_q   <= tag_in;
                popcnt  <= '0;
            end
            if (exam) begin
                if (last) tail <= 1'b1;
                else      idx  <= idx + 1'b1;
            end
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= exam_word;
                out_idx   <= idx;
                popcnt    <= popcnt + CW'(exam_cnt);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prm_chk_acc.sv
// Directed self-checking bench for prm_chk_acc at MASK_W=4096, WORD_W=32.
module tb_prm_chk_acc;

    localparam int MASK_W = 4096;
    localparam int WORD_W = 32;
    localparam int TAG_W  = 12;
    localparam int AW     = 7;
    localparam int CW     = 13;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              clr = 1'b0;
    logic              acc_en = 1'b0;
    logic [MASK_W-1:0] edge_mask = '0;
    logic [AW-1:0]     rd_addr = '0;
    logic [WORD_W-1:0] rd_data;
    logic              scan_start = 1'b0;
    logic              scan_skip0 = 1'b0;
    logic              scan_cor = 1'b0;
    logic [TAG_W-1:0]  tag_in = '0;
    logic [TAG_W-1:0]  tag_q;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WORD_W-1:0] out_data;
    logic [AW-1:0]     out_idx;
    logic              busy;
    logic              done;
    logic [CW-1:0]     popcnt;

    prm_chk_acc #(.MASK_W(MASK_W), .WORD_W(WORD_W), .TAG_W(TAG_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .clr        (clr),
        .acc_en     (acc_en),
        .edge_mask  (edge_mask),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .scan_start (scan_start),
        .scan_skip0 (scan_skip0),
        .scan_cor   (scan_cor),
        .tag_in     (tag_in),
        .tag_q      (tag_q),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done),
        .popcnt     (popcnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    int             nbeats;
    int             done_cyc;
    int             first_v;
    int             unstable;
    logic           busy_c1;
    logic [CW-1:0]  pop_done;
    logic [AW-1:0]  bidx [0:127];
    logic [31:0]    bdata [0:127];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_word(input int i, output logic [31:0] d);
        rd_addr = AW'(i);
        step();
        d = rd_data;
    endtask

    // Words holding bits 0, 33 and 4095
    function automatic logic [31:0] exp_w(input int i);
        if (i == 0)   return 32'h1;
        if (i == 1)   return 32'h2;
        if (i == 127) return 32'h8000_0000;
        return 32'h0;
    endfunction

    task automatic load_bits();
        clr = 1'b1;
        step();
        clr = 1'b0;
        edge_mask = '0;
        edge_mask[0] = 1'b1;
        edge_mask[33] = 1'b1;
        edge_mask[4095] = 1'b1;
        acc_en = 1'b1;
        step();
        acc_en = 1'b0;
        edge_mask = '0;
    endtask

    task automatic count_nonzero(output int nz);
        logic [31:0] d;
        nz = 0;
        for (int i = 0; i < 128; i++) begin
            read_word(i, d);
            if (d != 32'h0) nz++;
        end
    endtask

    task automatic run_scan(input bit skip0, input bit cor, input bit toggle, input bit race,
                            input logic [TAG_W-1:0] tag);
        logic        stalled;
        logic [31:0] held_d;
        logic [AW-1:0] held_i;
        int c;
        scan_skip0 = skip0;
        scan_cor   = cor;
        tag_in     = tag;
        out_ready  = 1'b1;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        nbeats = 0; done_cyc = 0; first_v = 0; unstable = 0;
        stalled = 1'b0; held_d = '0; held_i = '0;
        busy_c1 = busy;
        pop_done = '0;
        c = 1;
        while (c < 400) begin
            if (toggle) out_ready = (c % 2 == 1);
            acc_en = race && (c == 2);
            edge_mask = '0;
            if (race && c == 2) edge_mask[33] = 1'b1;
            if (stalled && (out_data !== held_d || out_idx !== held_i)) unstable++;
            if (out_valid && first_v == 0) first_v = c;
            if (out_valid && out_ready) begin
                if (nbeats < 128) begin
                    bidx[nbeats]  = out_idx;
                    bdata[nbeats] = out_data;
                end
                nbeats++;
            end
            stalled = out_valid && !out_ready;
            held_d = out_data;
            held_i = out_idx;
            if (done) begin
                done_cyc = c;
                pop_done = popcnt;
                break;
            end
            step();
            c++;
        end
        acc_en = 1'b0;
        edge_mask = '0;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        int nz;
        int bad;
        int c;
        bit found;

        // Reset state
        step();
        step();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_popcnt", popcnt, 0);
        chk("rst_tag_q", tag_q, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        RST = 1'b0;
        step();

        // Sticky accumulation
        edge_mask[5] = 1'b1;
        acc_en = 1'b1;
        step();
        edge_mask = '0;
        edge_mask[4000] = 1'b1;
        step();
        acc_en = 1'b0;
        edge_mask = '0;
        read_word(0, d);   chk("sticky_w0", d, 32'h20);
        read_word(125, d); chk("sticky_w125", d, 32'h1);
        step(); step(); step();
        read_word(0, d);   chk("sticky_w0_persist", d, 32'h20);
        read_word(125, d); chk("sticky_w125_persist", d, 32'h1);

        // clr and acc_en together
        clr = 1'b1;
        acc_en = 1'b1;
        edge_mask[7] = 1'b1;
        step();
        clr = 1'b0;
        acc_en = 1'b0;
        edge_mask = '0;
        read_word(0, d);
        chk("clr_en_w0", d, 32'h80);
        nz = 0;
        for (int i = 1; i < 128; i++) begin
            read_word(i, d);
            if (d != 32'h0) nz++;
        end
        chk("clr_en_others_zero", nz, 0);

        // Full scan, no skipping, no stalls
        load_bits();
        run_scan(1'b0, 1'b0, 1'b0, 1'b0, 12'hABC);
        chk("full_busy_t1", busy_c1, 1);
        chk("full_first_valid", first_v, 2);
        chk("full_done_cycle", done_cyc, 130);
        chk("full_beats", nbeats, 128);
        chk("full_popcnt", pop_done, 3);
        chk("full_tag", tag_q, 12'hABC);
        chk("full_beat0", bdata[0], 32'h1);
        chk("full_beat1", bdata[1], 32'h2);
        chk("full_beat127", bdata[127], 32'h8000_0000);
        bad = 0;
        for (int k = 0; k < 128 && k < nbeats; k++) begin
            if (bidx[k] != AW'(k) || bdata[k] != exp_w(k)) bad++;
        end
        chk("full_order_data", bad, 0);
        // scan_start during the done cycle is ignored
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        chk("start_in_done_ignored", busy, 0);
        step();

        // Skip-zero, clear-on-read, toggling backpressure
        run_scan(1'b1, 1'b1, 1'b1, 1'b0, 12'h123);
        chk("skip_beats", nbeats, 3);
        chk("skip_idx0", bidx[0], 0);
        chk("skip_idx1", bidx[1], 1);
        chk("skip_idx2", bidx[2], 127);
        chk("skip_data0", bdata[0], 32'h1);
        chk("skip_data1", bdata[1], 32'h2);
        chk("skip_data2", bdata[2], 32'h8000_0000);
        chk("skip_stable", unstable, 0);
        chk("skip_popcnt", pop_done, 3);
        chk("skip_done_seen", done_cyc != 0, 1);
        step();
        count_nonzero(nz);
        chk("cor_all_zero", nz, 0);

        // Clear-on-read racing with a new edge in word 1's capture cycle
        load_bits();
        run_scan(1'b0, 1'b1, 1'b0, 1'b1, 12'h055);
        chk("race_done_cycle", done_cyc, 130);
        chk("race_beat1", bdata[1], 32'h2);
        step();
        read_word(1, d);   chk("race_w1", d, 32'h2);
        read_word(0, d);   chk("race_w0", d, 32'h0);
        read_word(127, d); chk("race_w127", d, 32'h0);

        // Reset in the middle of a scan
        load_bits();
        scan_skip0 = 1'b0;
        scan_cor = 1'b0;
        tag_in = 12'h7E7;
        out_ready = 1'b1;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid && out_idx == AW'(10)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("mid_reach_beat10", found, 1);
        RST = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_popcnt", popcnt, 0);
        chk("mid_rst_tag", tag_q, 0);
        step();
        step();
        RST = 1'b0;
        scan_skip0 = 1'b1;
        scan_cor = 1'b0;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        chk("post_rst_start_accepted", busy, 1);
        c = 1;
        nbeats = 0;
        done_cyc = 0;
        while (c < 300) begin
            if (out_valid) nbeats++;
            if (done) begin
                done_cyc = c;
                break;
            end
            step();
            c++;
        end
        chk("zero_skip_done_cycle", done_cyc, 129);
        chk("zero_skip_beats", nbeats, 0);
        chk("zero_skip_popcnt", popcnt, 0);
        step();
        read_word(0, d);   chk("post_rst_w0", d, 0);
        read_word(1, d);   chk("post_rst_w1", d, 0);
        read_word(127, d); chk("post_rst_w127", d, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
